// File: rtl/camdenmil_sky25b_pkg.sv
// sky25b_pkg: shared constants and types for the camdenmil_sky25b timer/PWM block.
// Register addresses, CTRL bit positions and the CTRL register layout.
package sky25b_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PERIOD = 2'd1;
   localparam logic [1:0] ADDR_DUTY   = 2'd2;
   localparam logic [1:0] ADDR_PRESC  = 2'd3;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_ONESHOT = 1;
   localparam int CTRL_INV     = 2;
   localparam int CTRL_CLR     = 3;
   localparam int CTRL_RDSEL   = 4;

   localparam logic [7:0] UIO_OE_VAL = 8'hF0;

   typedef struct packed {
      logic [2:0] rsvd;
      logic       rdsel;
      logic       clr;
      logic       inv;
      logic       oneshot;
      logic       en;
   } ctrl_t;

   // Stored form of a CTRL write: reserved bits and the one-shot CLR strobe never persist.
   function automatic ctrl_t ctrl_from_byte(input logic [7:0] b);
      ctrl_t c;
      c      = ctrl_t'(b);
      c.rsvd = 3'b000;
      c.clr  = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/camdenmil_sky25b_if.sv
// camdenmil_sky25b_if: Tiny Tapeout style user pin bundle for the timer/PWM block.
// The master side drives ena/ui_in/uio_in; the slave (the design) drives the outputs.
interface camdenmil_sky25b_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
   modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/camdenmil_sky25b_regfile.sv
// sky25b_regfile: CTRL/PERIOD/DUTY/PRESCALE registers, write decode, CLR strobe,
// one-shot EN clearing and the readback mux.
// Build option SKY25B_PRESCALER_EN: when undefined the PRESCALE register does not
// exist, writes to address 3 are dropped and address 3 reads 8'h00.
module sky25b_regfile
   import sky25b_pkg::*;
#(
   parameter logic [7:0] PERIOD_RST = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       wr_en,
   input  logic [1:0] addr,
   input  logic [7:0] wdata,
   input  logic       oneshot_wrap,
   output ctrl_t      ctrl,
   output logic [7:0] period,
   output logic [7:0] duty,
`ifdef SKY25B_PRESCALER_EN
   output logic [7:0] presc,
`endif
   output logic       clr_hit,
   output logic [7:0] rdata
);

   ctrl_t      ctrl_q, ctrl_d;
   logic [7:0] period_q, period_d;
   logic [7:0] duty_q, duty_d;
`ifdef SKY25B_PRESCALER_EN
   logic [7:0] presc_q, presc_d;
`endif
   logic       wr_fire;

   assign wr_fire = ena & wr_en;
   assign clr_hit = wr_fire & (addr == ADDR_CTRL) & wdata[CTRL_CLR];

   // Next register values: one-shot wrap drops EN, a CPU write to the same register wins.
   always_comb begin
      ctrl_d   = ctrl_q;
      period_d = period_q;
      duty_d   = duty_q;
`ifdef SKY25B_PRESCALER_EN
      presc_d  = presc_q;
`endif
      if (oneshot_wrap) ctrl_d.en = 1'b0;
      if (wr_fire) begin
         case (addr)
            ADDR_CTRL:   ctrl_d   = ctrl_from_byte(wdata);
            ADDR_PERIOD: period_d = wdata;
            ADDR_DUTY:   duty_d   = wdata;
`ifdef SKY25B_PRESCALER_EN
            default:     presc_d  = wdata;
`else
            default:     ;
`endif
         endcase
      end
   end

   // Register state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q   <= '0;
         period_q <= PERIOD_RST;
         duty_q   <= 8'h00;
`ifdef SKY25B_PRESCALER_EN
         presc_q  <= 8'h00;
`endif
      end else begin
         ctrl_q   <= ctrl_d;
         period_q <= period_d;
         duty_q   <= duty_d;
`ifdef SKY25B_PRESCALER_EN
         presc_q  <= presc_d;
`endif
      end
   end

   // Readback selected by the live address bits.
   always_comb begin
      case (addr)
         ADDR_CTRL:   rdata = ctrl_q;
         ADDR_PERIOD: rdata = period_q;
         ADDR_DUTY:   rdata = duty_q;
`ifdef SKY25B_PRESCALER_EN
         default:     rdata = presc_q;
`else
         default:     rdata = 8'h00;
`endif
      endcase
   end

   assign ctrl   = ctrl_q;
   assign period = period_q;
   assign duty   = duty_q;
`ifdef SKY25B_PRESCALER_EN
   assign presc  = presc_q;
`endif

endmodule

// File: rtl/camdenmil_sky25b.sv
// camdenmil_sky25b: 8-bit programmable timer/PWM peripheral on the Tiny Tapeout pin set.
// Holds the prescaler, counter, PWM compare and output mapping; registers live in
// sky25b_regfile. Build option SKY25B_PRESCALER_EN enables the PRESCALE divider;
// without it the counter ticks every enabled cycle.
module camdenmil_sky25b
   import sky25b_pkg::*;
#(
   parameter logic [7:0] PERIOD_RST = 8'hFF
) (
   input  logic                clk,
   input  logic                rst_n,
   camdenmil_sky25b_if.slave   bus
);

   ctrl_t      ctrl;
   logic [7:0] period;
   logic [7:0] duty;
   logic [7:0] rdata;
   logic       clr_hit;
   logic       tick_now;
   logic       wrap_now;
   logic [7:0] cnt_q, cnt_d;
   logic       tick_q, tick_d;
   logic       wrap_q, wrap_d;
   logic       pwm;
   logic       unused_bits;

`ifdef SKY25B_PRESCALER_EN
   logic [7:0] presc;
   logic [7:0] pre_q, pre_d;
`endif

   sky25b_regfile #(.PERIOD_RST(PERIOD_RST)) u_regfile (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (bus.ena),
      .wr_en        (bus.uio_in[2]),
      .addr         (bus.uio_in[1:0]),
      .wdata        (bus.ui_in),
      .oneshot_wrap (wrap_now & ctrl.oneshot),
      .ctrl         (ctrl),
      .period       (period),
      .duty         (duty),
`ifdef SKY25B_PRESCALER_EN
      .presc        (presc),
`endif
      .clr_hit      (clr_hit),
      .rdata        (rdata)
   );

`ifdef SKY25B_PRESCALER_EN
   // Prescaler: count up to PRESCALE, then emit a tick and restart; CLR zeroes it.
   always_comb begin
      pre_d    = pre_q;
      tick_now = 1'b0;
      if (bus.ena) begin
         if (clr_hit) begin
            pre_d = 8'h00;
         end else if (ctrl.en) begin
            if (pre_q == presc) begin
               tick_now = 1'b1;
               pre_d    = 8'h00;
            end else begin
               pre_d = pre_q + 8'd1;
            end
         end
      end
   end

   // Prescaler state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pre_q <= 8'h00;
      else        pre_q <= pre_d;
   end
`else
   assign tick_now = bus.ena & ctrl.en;
`endif

   // Counter and status pulses; CLR beats a coincident tick, ena=0 freezes everything.
   always_comb begin
      cnt_d    = cnt_q;
      tick_d   = tick_q;
      wrap_d   = wrap_q;
      wrap_now = 1'b0;
      if (bus.ena) begin
         tick_d = 1'b0;
         wrap_d = 1'b0;
         if (clr_hit) begin
            cnt_d = 8'h00;
         end else if (tick_now) begin
            tick_d = 1'b1;
            if (cnt_q >= period) begin
               cnt_d    = 8'h00;
               wrap_now = 1'b1;
               wrap_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
      end
   end

   // Counter and pulse state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 8'h00;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         wrap_q <= wrap_d;
      end
   end

   // DUTY=0 never matches, DUTY>PERIOD always matches; INV flips polarity.
   assign pwm = (cnt_q < duty) ^ ctrl.inv;

   assign bus.uo_out  = ctrl.rdsel ? rdata : cnt_q;
   assign bus.uio_out = {ctrl.en, tick_q, wrap_q, pwm, 4'b0000};
   assign bus.uio_oe  = UIO_OE_VAL;

   // Upper uio_in bits and the non-persistent CTRL fields carry no function here.
   assign unused_bits = &{1'b0, bus.uio_in[7:3], ctrl.rsvd, ctrl.clr};

endmodule

// File: tb/tb_camdenmil_sky25b.sv
// tb_camdenmil_sky25b: directed bench for the camdenmil_sky25b timer/PWM block.
// Expectations follow SKY25B_PRESCALER_EN the same way the design does.
module tb_camdenmil_sky25b;
   import sky25b_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   camdenmil_sky25b_if bus();

   camdenmil_sky25b #(.PERIOD_RST(8'hFF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Test 2: PERIOD=3, DUTY=2, tick every cycle.
   logic [7:0] t2_cnt  [0:7] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
   logic       t2_wrap [0:7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic       t2_pwm  [0:7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

   // Test 3: PERIOD=1, PRESCALE=2 (divider only in the prescaler build).
`ifdef SKY25B_PRESCALER_EN
   localparam int T3_N = 9;
   logic [7:0] t3_cnt  [0:T3_N-1] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
   logic       t3_tick [0:T3_N-1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic       t3_wrap [0:T3_N-1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam logic [7:0] T3_PRESC_RD = 8'h02;
`else
   localparam int T3_N = 6;
   logic [7:0] t3_cnt  [0:T3_N-1] = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0};
   logic       t3_tick [0:T3_N-1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   logic       t3_wrap [0:T3_N-1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   localparam logic [7:0] T3_PRESC_RD = 8'h00;
`endif

   // Test 4: ONESHOT with PERIOD=2, DUTY=2.
   logic [7:0] t4_cnt  [0:4] = '{8'd1, 8'd2, 8'd0, 8'd0, 8'd0};
   logic       t4_run  [0:4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   logic       t4_tick [0:4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic       t4_wrap [0:4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic       t4_pwm  [0:4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] st(input logic run, input logic tick,
                                     input logic wrap, input logic pwm);
      return {run, tick, wrap, pwm, 4'b0000};
   endfunction

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      bus.ui_in  = d;
      bus.uio_in = {5'b00000, 1'b1, a};
      cycle();
      bus.uio_in = {6'b000000, a};
   endtask

   task automatic rd(input logic [1:0] a);
      bus.uio_in = {6'b000000, a};
      #1;
   endtask

   initial begin
      bus.ena    = 1'b1;
      bus.ui_in  = 8'h00;
      bus.uio_in = 8'h00;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);

      // 1. reset state and PERIOD reset readback
      check("rst uo_out", bus.uo_out, 8'h00);
      check("rst uio_out", bus.uio_out, 8'h00);
      check("rst uio_oe", bus.uio_oe, 8'hF0);
      rst_n = 1'b1;
      cycle();
      check("rst hold uo_out", bus.uo_out, 8'h00);
      wr(ADDR_CTRL, 8'h10);
      rd(ADDR_PERIOD);
      check("rst period rd", bus.uo_out, 8'hFF);
      wr(ADDR_CTRL, 8'hF8);
      rd(ADDR_CTRL);
      check("ctrl clr/rsvd rd0", bus.uo_out, 8'h10);
      rd(ADDR_DUTY);
      check("rst duty rd", bus.uo_out, 8'h00);
      wr(ADDR_CTRL, 8'h00);

      // 2. free-running count, PWM and wrap
      wr(ADDR_PRESC, 8'h00);
      wr(ADDR_PERIOD, 8'h03);
      wr(ADDR_DUTY, 8'h02);
      wr(ADDR_CTRL, 8'h01);
      check("t2 start cnt", bus.uo_out, 8'h00);
      check("t2 start st", bus.uio_out, st(1'b1, 1'b0, 1'b0, 1'b1));
      for (int i = 0; i < 8; i++) begin
         cycle();
         check($sformatf("t2 cnt[%0d]", i), bus.uo_out, t2_cnt[i]);
         check($sformatf("t2 st[%0d]", i), bus.uio_out, st(1'b1, 1'b1, t2_wrap[i], t2_pwm[i]));
      end

      // 3. prescaled count
      wr(ADDR_CTRL, 8'h08);
      check("t3 clr cnt", bus.uo_out, 8'h00);
      wr(ADDR_PERIOD, 8'h01);
      wr(ADDR_PRESC, 8'h02);
      wr(ADDR_CTRL, 8'h01);
      for (int i = 0; i < T3_N; i++) begin
         cycle();
         check($sformatf("t3 cnt[%0d]", i), bus.uo_out, t3_cnt[i]);
         check($sformatf("t3 st[%0d]", i), bus.uio_out, st(1'b1, t3_tick[i], t3_wrap[i], 1'b1));
      end
      wr(ADDR_CTRL, 8'h10);
      rd(ADDR_CTRL);
      check("t3 ctrl rd", bus.uo_out, 8'h10);
      rd(ADDR_PERIOD);
      check("t3 period rd", bus.uo_out, 8'h01);
      rd(ADDR_DUTY);
      check("t3 duty rd", bus.uo_out, 8'h02);
      rd(ADDR_PRESC);
      check("t3 presc rd", bus.uo_out, T3_PRESC_RD);

      // 4. one-shot
      wr(ADDR_CTRL, 8'h08);
      wr(ADDR_PRESC, 8'h00);
      wr(ADDR_PERIOD, 8'h02);
      wr(ADDR_CTRL, 8'h03);
      check("t4 start cnt", bus.uo_out, 8'h00);
      for (int i = 0; i < 5; i++) begin
         cycle();
         check($sformatf("t4 cnt[%0d]", i), bus.uo_out, t4_cnt[i]);
         check($sformatf("t4 st[%0d]", i), bus.uio_out,
               st(t4_run[i], t4_tick[i], t4_wrap[i], t4_pwm[i]));
      end

      // 5. DUTY>PERIOD, INV, DUTY=0
      wr(ADDR_CTRL, 8'h08);
      wr(ADDR_PERIOD, 8'd10);
      wr(ADDR_DUTY, 8'hFF);
      wr(ADDR_CTRL, 8'h01);
      for (int i = 0; i < 12; i++) begin
         cycle();
         check($sformatf("t5 pwm hi[%0d]", i), {7'b0, bus.uio_out[4]}, 8'h01);
      end
      wr(ADDR_CTRL, 8'h05);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check($sformatf("t5 pwm inv[%0d]", i), {7'b0, bus.uio_out[4]}, 8'h00);
      end
      wr(ADDR_CTRL, 8'h01);
      wr(ADDR_DUTY, 8'h00);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check($sformatf("t5 pwm duty0[%0d]", i), {7'b0, bus.uio_out[4]}, 8'h00);
      end

      // 6. mid-count CLR, ena freeze, async reset
      wr(ADDR_CTRL, 8'h08);
      wr(ADDR_DUTY, 8'h05);
      wr(ADDR_PERIOD, 8'd10);
      wr(ADDR_CTRL, 8'h01);
      repeat (3) cycle();
      check("t6 pre-clr cnt", bus.uo_out, 8'h03);
      wr(ADDR_CTRL, 8'h09);
      check("t6 clr cnt", bus.uo_out, 8'h00);
      check("t6 clr st", bus.uio_out, st(1'b1, 1'b0, 1'b0, 1'b1));
      cycle();
      check("t6 post-clr cnt", bus.uo_out, 8'h01);
      bus.ena = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cycle();
         check($sformatf("t6 freeze cnt[%0d]", i), bus.uo_out, 8'h01);
         check($sformatf("t6 freeze st[%0d]", i), bus.uio_out, st(1'b1, 1'b1, 1'b0, 1'b1));
      end
      wr(ADDR_PERIOD, 8'h55);
      check("t6 freeze wr cnt", bus.uo_out, 8'h01);
      bus.ena = 1'b1;
      cycle();
      check("t6 resume cnt", bus.uo_out, 8'h02);
      wr(ADDR_CTRL, 8'h10);
      rd(ADDR_PERIOD);
      check("t6 period kept", bus.uo_out, 8'd10);
      wr(ADDR_CTRL, 8'h01);
      check("t6 cnt after en", bus.uo_out, 8'h03);
      repeat (2) cycle();
      check("t6 cnt before rst", bus.uo_out, 8'h05);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6 async uo_out", bus.uo_out, 8'h00);
      check("t6 async uio_out", bus.uio_out, 8'h00);
      check("t6 async uio_oe", bus.uio_oe, 8'hF0);
      @(negedge clk);
      rst_n = 1'b1;
      wr(ADDR_CTRL, 8'h10);
      rd(ADDR_PERIOD);
      check("t6 period after rst", bus.uo_out, 8'hFF);
      rd(ADDR_DUTY);
      check("t6 duty after rst", bus.uo_out, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
